// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-step sequencer for an external 8-bit combinational barrel shifter.
//
// A request carries an operand, a direction and a total shift amount of up to 2**AmtW-1.
// The shifter can only move by 0..2**ShW-1 positions per pass, so the request is split into
// steps of at most MaxStep. The accumulator is routed through the shifter once per RUN cycle,
// and the shifter's result is registered back each cycle. The final value is presented on
// dout_o, and done_o pulses for one cycle.
//
// Optional feature (compile-time macro SHIFT_SAT_EN):
//   defined   - a request with amt_i >= Width clears the accumulator and goes straight to
//               DONE in one edge, skipping RUN.
//   undefined - every nonzero amount iterates through RUN. The result is the same; only the
//               latency differs.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous reset, active-high
//   start_i     request strobe; sampled only in IDLE or DONE
//   din_i       operand
//   lr_i        direction: 1 = left, 0 = right
//   amt_i       total shift amount
//   sh_in_o     shifter data input (accumulator)
//   sh_lr_o     shifter direction (latched lr_i)
//   sh_n_o      shifter amount: min(remaining, MaxStep) in RUN, 0 otherwise
//   sh_out_i    shifter result (logical, zero fill)
//   busy_o      high while in RUN
//   done_o      one-cycle pulse in DONE
//   dout_o      result; holds until the next accepted start

module shift_seq_ctrl #(
  parameter int unsigned Width = 8,
  parameter int unsigned ShW   = 3,
  parameter int unsigned AmtW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Width-1:0] din_i,
  input  logic             lr_i,
  input  logic [AmtW-1:0]  amt_i,
  output logic [Width-1:0] sh_in_o,
  output logic             sh_lr_o,
  output logic [ShW-1:0]   sh_n_o,
  input  logic [Width-1:0] sh_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] dout_o
);

  // Largest amount the shifter accepts in one pass.
  localparam logic [AmtW-1:0] MaxStep = AmtW'((2 ** ShW) - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e             state_q;
  logic [Width-1:0]   acc_q;
  logic [AmtW-1:0]    rem_q;
  logic               dir_q;

  logic [ShW-1:0]     step;
  logic [AmtW-1:0]    rem_next;
  logic               sat_hit;

  // Step size for this RUN cycle. Because step <= rem_q, the subtraction below never wraps.
  always_comb begin
    step = '0;
    if (state_q == StRun) begin
      if (rem_q > MaxStep) begin
        step = MaxStep[ShW-1:0];
      end else begin
        step = rem_q[ShW-1:0];
      end
    end
  end

  assign rem_next = rem_q - AmtW'(step);

  // Any amount of at least Width clears the operand. The shortcut recognises this at start.
`ifdef SHIFT_SAT_EN
  assign sat_hit = (amt_i >= AmtW'(Width));
`else
  assign sat_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            dir_q <= lr_i;
            if (sat_hit) begin
              acc_q   <= '0;
              rem_q   <= '0;
              state_q <= StDone;
            end else begin
              acc_q <= din_i;
              rem_q <= amt_i;
              // A zero amount needs no shifter pass; the operand itself is the result.
              if (amt_i == '0) begin
                state_q <= StDone;
              end else begin
                state_q <= StRun;
              end
            end
          end else if (state_q == StDone) begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          // start_i is deliberately ignored here: no reload, no queueing.
          acc_q <= sh_out_i;
          rem_q <= rem_next;
          if (rem_next == '0) begin
            state_q <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // All outputs come from registers. There is no path from request inputs to outputs.
  assign sh_in_o = acc_q;
  assign sh_lr_o = dir_q;
  assign sh_n_o  = step;
  assign busy_o  = (state_q == StRun);
  assign done_o  = (state_q == StDone);
  assign dout_o  = acc_q;

endmodule
